// File: rtl/sine_pkg.sv
// Shared constants for the sine generator: default parameters, quadrant
// naming and the quarter-wave magnitude table (DATA_WIDTH=16, LUT_DEPTH=8).
package sine_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_LUT_DEPTH   = 8;
    localparam int DEF_PHASE_WIDTH = 64;

    localparam int QTR_ENTRIES = (1 << (DEF_LUT_DEPTH - 2)) + 1;

    typedef enum logic [1:0] {
        QUAD_RISE      = 2'd0,
        QUAD_FALL      = 2'd1,
        QUAD_NEG_FALL  = 2'd2,
        QUAD_NEG_RISE  = 2'd3
    } quadrant_e;

    // round(32767 * sin(2*pi*i/256)) for i = 0..64; entry 64 is the peak.
    localparam logic [15:0] QTR_TABLE [QTR_ENTRIES] = '{
        16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,
        16'd4011,  16'd4808,  16'd5602,  16'd6393,  16'd7179,
        16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039,
        16'd11793, 16'd12539, 16'd13279, 16'd14010, 16'd14732,
        16'd15446, 16'd16151, 16'd16846, 16'd17530, 16'd18204,
        16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403,
        16'd22005, 16'd22594, 16'd23170, 16'd23731, 16'd24279,
        16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
        16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898,
        16'd29268, 16'd29621, 16'd29956, 16'd30273, 16'd30571,
        16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785,
        16'd31971, 16'd32137, 16'd32285, 16'd32412, 16'd32521,
        16'd32609, 16'd32678, 16'd32728, 16'd32757, 16'd32767
    };

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational full-cycle sine lookup folded onto the quarter-wave table:
// odd quadrants mirror the index, upper-half quadrants negate the magnitude.
module sine_quarter_rom
    import sine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH
) (
    input  logic [LUT_DEPTH-1:0]         addr_i,
    output logic signed [DATA_WIDTH-1:0] sample_o
);

    localparam logic [LUT_DEPTH-2:0] QTR_SPAN = (LUT_DEPTH-1)'(1 << (LUT_DEPTH - 2));

    quadrant_e              quad;
    logic [LUT_DEPTH-3:0]   low;
    logic [LUT_DEPTH-2:0]   idx;
    logic [DATA_WIDTH-1:0]  mag;

    assign quad = quadrant_e'(addr_i[LUT_DEPTH-1 -: 2]);
    assign low  = addr_i[LUT_DEPTH-3:0];

    always_comb begin
        idx      = {1'b0, low};
        mag      = '0;
        sample_o = '0;
        // Falling quadrants read the table backwards from the peak entry.
        if (quad == QUAD_FALL || quad == QUAD_NEG_RISE) begin
            idx = QTR_SPAN - {1'b0, low};
        end
        mag = DATA_WIDTH'(QTR_TABLE[idx]);
        if (quad == QUAD_NEG_FALL || quad == QUAD_NEG_RISE) begin
            sample_o = $signed(DATA_WIDTH'(0) - mag);
        end else begin
            sample_o = $signed(mag);
        end
    end

endmodule

// File: rtl/sinewave_generator.sv
// DDS sine source: a phase accumulator advanced once per sample enable and a
// registered output sampled from the lookup of the pre-update phase.
module sinewave_generator
    import sine_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LUT_DEPTH   = DEF_LUT_DEPTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          sample_clk_ce,
    input  logic [PHASE_WIDTH-1:0]        phase_increment,
    output logic signed [DATA_WIDTH-1:0]  sinewave
);

    logic [PHASE_WIDTH-1:0]        acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  sample_q, sample_d;
    logic signed [DATA_WIDTH-1:0]  rom_sample;

    sine_quarter_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .LUT_DEPTH  (LUT_DEPTH)
    ) u_rom (
        .addr_i   (acc_q[PHASE_WIDTH-1 -: LUT_DEPTH]),
        .sample_o (rom_sample)
    );

    // Carry out of the accumulator is dropped so the phase wraps silently.
    always_comb begin
        acc_d    = acc_q;
        sample_d = sample_q;
        if (sample_clk_ce) begin
            acc_d    = acc_q + phase_increment;
            sample_d = rom_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            acc_q    <= '0;
            sample_q <= '0;
        end else begin
            acc_q    <= acc_d;
            sample_q <= sample_d;
        end
    end

    assign sinewave = sample_q;

endmodule

// File: tb/tb_sinewave_generator.sv
// Directed bench for sinewave_generator: a phase/sine model computed with real
// arithmetic, a per-cycle output compare, and literal sample checks.
module tb_sinewave_generator;

    localparam int DW = 16;
    localparam int LD = 8;
    localparam int PW = 64;

    localparam logic [PW-1:0] INC_QUARTER = 64'h4000_0000_0000_0000;
    localparam logic [PW-1:0] INC_STEP1   = 64'h0100_0000_0000_0000;
    localparam logic [PW-1:0] INC_NEG     = 64'hC000_0000_0000_0000;

    logic                  clk = 1'b0;
    logic                  arst = 1'b1;
    logic                  ce = 1'b0;
    logic [PW-1:0]         inc = '0;
    logic signed [DW-1:0]  sinewave;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q[$];
    logic [PW-1:0] m_acc = '0;

    sinewave_generator #(
        .DATA_WIDTH  (DW),
        .LUT_DEPTH   (LD),
        .PHASE_WIDTH (PW)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .sample_clk_ce   (ce),
        .phase_increment (inc),
        .sinewave        (sinewave)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Ideal sine value for table address a, rounded half away from zero.
    function automatic int model_lut(input int a);
        real amp;
        real x;
        amp = real'((2 ** (DW - 1)) - 1);
        x   = amp * $sin(2.0 * 3.141592653589793 * real'(a) / real'(2 ** LD));
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int cur_exp();
        if (exp_q.size() == 0) return 0;
        return int'($signed(exp_q[$]));
    endfunction

    // model: history of expected samples, cleared by reset
    initial begin
        forever begin
            @(posedge clk);
            if (arst) begin
                m_acc = '0;
                exp_q.delete();
            end else if (ce) begin
                exp_q.push_back(DW'(model_lut(int'(m_acc[PW-1 -: LD]))));
                m_acc = m_acc + inc;
            end
        end
    end

    // per-cycle compare on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            n_tests++;
            if (int'(sinewave) != cur_exp()) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t sinewave=%0d expected=%0d",
                         $time, int'(sinewave), cur_exp());
            end
        end
    end

    // driver tasks
    task automatic step(input logic c, input logic [PW-1:0] i);
        ce  = c;
        inc = i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        arst = 1'b1;
        ce   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    task automatic check_lit(input string name, input int exp);
        n_tests++;
        if (int'(sinewave) != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t sinewave=%0d expected=%0d", name, $time, int'(sinewave), exp);
        end
        n_tests++;
        if (cur_exp() != exp) begin
            n_fail++;
            $display("FAIL model_%s t=%0t model=%0d expected=%0d", name, $time, cur_exp(), exp);
        end
    endtask

    int seq4[4] = '{0, 32767, 0, -32767};
    int seqn[4] = '{0, -32767, 0, 32767};

    initial begin
        do_reset(2);
        check_lit("reset", 0);

        // quarter-cycle steps, enable every cycle
        for (int k = 0; k < 8; k++) begin
            step(1'b1, INC_QUARTER);
            check_lit("quarter", seq4[k % 4]);
        end

        // enable every fourth cycle; output holds in between
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, INC_QUARTER);
            check_lit("ce_edge", seq4[k % 4]);
            for (int h = 0; h < 3; h++) begin
                step(1'b0, INC_QUARTER);
                check_lit("ce_hold", seq4[k % 4]);
            end
        end

        // one table address per sample, full period plus wrap
        do_reset(1);
        for (int k = 0; k <= 256; k++) begin
            step(1'b1, INC_STEP1);
            if (k == 1)   check_lit("step_s1", 804);
            if (k == 2)   check_lit("step_s2", 1608);
            if (k == 64)  check_lit("step_s64", 32767);
            if (k == 128) check_lit("step_s128", 0);
            if (k == 192) check_lit("step_s192", -32767);
            if (k == 256) check_lit("step_wrap", 0);
        end

        // reset mid-run with enable high
        arst = 1'b1;
        step(1'b1, INC_STEP1);
        check_lit("rst_mid", 0);
        arst = 1'b0;
        step(1'b1, INC_STEP1);
        check_lit("rst_first", 0);
        step(1'b1, INC_STEP1);
        check_lit("rst_second", 804);

        // increment switch keeps phase continuous
        do_reset(1);
        for (int k = 0; k < 10; k++) step(1'b1, INC_STEP1);
        check_lit("sw_before", 7179);
        step(1'b1, INC_QUARTER);
        check_lit("sw_a10", 7962);
        step(1'b1, INC_QUARTER);
        check_lit("sw_a74", 31785);
        step(1'b1, INC_QUARTER);
        check_lit("sw_a138", -7962);
        step(1'b1, INC_QUARTER);
        check_lit("sw_a202", -31785);

        // negative step wraps backwards
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, INC_NEG);
            check_lit("neg", seqn[k % 4]);
        end

        // zero increment freezes the phase (address 192 now)
        step(1'b1, '0);
        check_lit("freeze_a", -32767);
        step(1'b1, '0);
        check_lit("freeze_b", -32767);

        // reset wins with enable low
        arst = 1'b1;
        step(1'b0, INC_STEP1);
        check_lit("rst_ce0", 0);
        arst = 1'b0;
        step(1'b0, INC_STEP1);
        check_lit("rst_ce0_hold", 0);

        repeat (3) step(1'b1, INC_STEP1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
